// File: rtl/apmu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apmu_regfile_pkg
// Brief    : Shared types for the APMU multi-port register file and its
//            context save/restore engine.
// Revision : 1.0 - initial release
// ============================================================================
package apmu_regfile_pkg;

  // Context engine states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } ctx_state_e;

endpackage : apmu_regfile_pkg
`default_nettype wire

// File: rtl/apmu_regfile_ctx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : apmu_regfile_ctx_fsm
// Brief    : Context save/restore sequencer. Walks registers 1..NumWords-1
//            over valid/ready streams and drives the restore write port.
// Revision : 1.0 - initial release
// ============================================================================
module apmu_regfile_ctx_fsm
  import apmu_regfile_pkg::*;
#(
  parameter int AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  input  logic                 sv_ready_i,
  input  logic                 rs_valid_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sv_valid_o,
  output logic [AddrWidth-1:0] sv_idx_o,
  output logic                 rs_ready_o,
  output logic                 rs_we_o,
  output logic [AddrWidth-1:0] rs_addr_o
);

  // Last register index; reaching it ends the stream without wrapping idx.
  localparam logic [AddrWidth-1:0] c_LAST_IDX  = '1;
  localparam logic [AddrWidth-1:0] c_FIRST_IDX = AddrWidth'(1);

  ctx_state_e             r_state;
  ctx_state_e             w_state_next;
  logic [AddrWidth-1:0]   r_idx;
  logic [AddrWidth-1:0]   w_idx_next;
  logic                   w_xfer;

  // State and index registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state and index update; save has priority over restore in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_xfer       = ((r_state == SAVE) && sv_ready_i) ||
                   ((r_state == RESTORE) && rs_valid_i);
    case (r_state)
      IDLE: begin
        if (save_req_i) begin
          w_state_next = SAVE;
          w_idx_next   = c_FIRST_IDX;
        end else if (restore_req_i) begin
          w_state_next = RESTORE;
          w_idx_next   = c_FIRST_IDX;
        end
      end
      SAVE, RESTORE: begin
        if (w_xfer) begin
          if (r_idx == c_LAST_IDX) begin
            w_state_next = DONE;
          end else begin
            w_idx_next = r_idx + c_FIRST_IDX;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Handshake and restore-port outputs decoded from the current state.
  always_comb begin
    busy_o     = (r_state != IDLE);
    done_o     = (r_state == DONE);
    sv_valid_o = (r_state == SAVE);
    sv_idx_o   = (r_state == SAVE) ? r_idx : '0;
    rs_ready_o = (r_state == RESTORE);
    rs_we_o    = (r_state == RESTORE) && rs_valid_i;
    rs_addr_o  = r_idx;
  end

endmodule : apmu_regfile_ctx_fsm
`default_nettype wire

// File: rtl/apmu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : apmu_regfile_mp
// Brief    : Parametrised multi-port FF register file (R0 hard-wired to zero)
//            with write priority, optional bypass, conflict flag and a
//            context save/restore engine.
// Revision : 1.0 - initial release
// ============================================================================
module apmu_regfile_mp
  import apmu_regfile_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 5,
  parameter int NumRead     = 2,
  parameter int NumWrite    = 2,
  parameter int WriteBypass = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumRead-1:0][AddrWidth-1:0]  raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0]  rdata_o,
  input  logic [NumWrite-1:0][AddrWidth-1:0] waddr_i,
  input  logic [NumWrite-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]                we_i,
  output logic                               wr_conflict_o,
  input  logic                               ctx_save_req_i,
  input  logic                               ctx_restore_req_i,
  output logic                               ctx_busy_o,
  output logic                               ctx_done_o,
  output logic                               sv_valid_o,
  input  logic                               sv_ready_i,
  output logic [AddrWidth-1:0]               sv_idx_o,
  output logic [DataWidth-1:0]               sv_data_o,
  input  logic                               rs_valid_i,
  output logic                               rs_ready_o,
  input  logic [DataWidth-1:0]               rs_data_i
);

  localparam int c_NUM_WORDS = 2 ** AddrWidth;

  // Entry 0 exists only so reads of R0 index a constant-zero word.
  logic [DataWidth-1:0]   r_mem [c_NUM_WORDS];
  logic [c_NUM_WORDS-1:0] w_wr_en;
  logic [DataWidth-1:0]   w_wr_data [c_NUM_WORDS];
  logic                   w_conflict;
  logic                   r_wr_conflict;
  logic                   w_rs_we;
  logic [AddrWidth-1:0]   w_rs_addr;

  apmu_regfile_ctx_fsm #(
    .AddrWidth (AddrWidth)
  ) u_ctx_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .save_req_i    (ctx_save_req_i),
    .restore_req_i (ctx_restore_req_i),
    .sv_ready_i    (sv_ready_i),
    .rs_valid_i    (rs_valid_i),
    .busy_o        (ctx_busy_o),
    .done_o        (ctx_done_o),
    .sv_valid_o    (sv_valid_o),
    .sv_idx_o      (sv_idx_o),
    .rs_ready_o    (rs_ready_o),
    .rs_we_o       (w_rs_we),
    .rs_addr_o     (w_rs_addr)
  );

  // Per-word write decode: later ports override earlier ones, restore path
  // only acts while busy (when architectural writes are locked out).
  always_comb begin
    w_wr_en = '0;
    for (int a = 0; a < c_NUM_WORDS; a++) begin
      w_wr_data[a] = '0;
    end
    if (!ctx_busy_o) begin
      for (int p = 0; p < NumWrite; p++) begin
        if (we_i[p] && (waddr_i[p] != '0)) begin
          w_wr_en[waddr_i[p]]   = 1'b1;
          w_wr_data[waddr_i[p]] = wdata_i[p];
        end
      end
    end
    if (w_rs_we && (w_rs_addr != '0)) begin
      w_wr_en[w_rs_addr]   = 1'b1;
      w_wr_data[w_rs_addr] = rs_data_i;
    end
  end

  // Conflict detect: any two enabled ports on the same nonzero address.
  always_comb begin
    w_conflict = 1'b0;
    if (!ctx_busy_o) begin
      for (int i = 0; i < NumWrite; i++) begin
        for (int j = i + 1; j < NumWrite; j++) begin
          if (we_i[i] && we_i[j] && (waddr_i[i] == waddr_i[j]) &&
              (waddr_i[i] != '0)) begin
            w_conflict = 1'b1;
          end
        end
      end
    end
  end

  // Storage update; w_wr_en[0] is never set so word 0 stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int a = 0; a < c_NUM_WORDS; a++) begin
        r_mem[a] <= '0;
      end
    end else begin
      for (int a = 0; a < c_NUM_WORDS; a++) begin
        if (w_wr_en[a]) begin
          r_mem[a] <= w_wr_data[a];
        end
      end
    end
  end

  // Registered conflict pulse, one cycle after the offending writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_conflict <= w_conflict;
    end
  end

  // Read ports with optional forwarding of the winning same-cycle write.
  always_comb begin
    for (int r = 0; r < NumRead; r++) begin
      rdata_o[r] = r_mem[raddr_i[r]];
      if ((WriteBypass != 0) && w_wr_en[raddr_i[r]]) begin
        rdata_o[r] = w_wr_data[raddr_i[r]];
      end
    end
  end

  assign wr_conflict_o = r_wr_conflict;
  assign sv_data_o     = r_mem[sv_idx_o];

endmodule : apmu_regfile_mp
`default_nettype wire

// File: tb/tb_apmu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_apmu_regfile_mp
// Brief    : Directed self-checking bench for apmu_regfile_mp. Two instances
//            share stimulus: dut (no bypass) and dut_bp (bypass enabled).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apmu_regfile_mp;

  logic             clk;
  logic             rst;
  logic [1:0][4:0]  raddr;
  logic [1:0][31:0] rdata;
  logic [1:0][31:0] bp_rdata;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic             conflict, bp_conflict;
  logic             save_req, restore_req;
  logic             busy, bp_busy, done, bp_done;
  logic             sv_valid, bp_sv_valid, sv_ready;
  logic [4:0]       sv_idx, bp_sv_idx;
  logic [31:0]      sv_data, bp_sv_data;
  logic             rs_valid, rs_ready, bp_rs_ready;
  logic [31:0]      rs_data;

  int n_cmp;
  int n_fail;

  apmu_regfile_mp #(
    .DataWidth(32), .AddrWidth(5), .NumRead(2), .NumWrite(2), .WriteBypass(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wr_conflict_o(conflict),
    .ctx_save_req_i(save_req), .ctx_restore_req_i(restore_req),
    .ctx_busy_o(busy), .ctx_done_o(done), .sv_valid_o(sv_valid),
    .sv_ready_i(sv_ready), .sv_idx_o(sv_idx), .sv_data_o(sv_data),
    .rs_valid_i(rs_valid), .rs_ready_o(rs_ready), .rs_data_i(rs_data)
  );

  apmu_regfile_mp #(
    .DataWidth(32), .AddrWidth(5), .NumRead(2), .NumWrite(2), .WriteBypass(1)
  ) dut_bp (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(bp_rdata),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wr_conflict_o(bp_conflict),
    .ctx_save_req_i(save_req), .ctx_restore_req_i(restore_req),
    .ctx_busy_o(bp_busy), .ctx_done_o(bp_done), .sv_valid_o(bp_sv_valid),
    .sv_ready_i(sv_ready), .sv_idx_o(bp_sv_idx), .sv_data_o(bp_sv_data),
    .rs_valid_i(rs_valid), .rs_ready_o(bp_rs_ready), .rs_data_i(rs_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic test_reset();
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0;
    save_req = 1'b0; restore_req = 1'b0; sv_ready = 1'b1;
    rs_valid = 1'b0; rs_data = '0;
    raddr[0] = 5'd5; raddr[1] = 5'd31;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (sv_valid !== 1'b0) begin n_fail++; $display("FAIL rst_sv_valid: got %b want 0", sv_valid); end
    n_cmp++; if (sv_idx !== 5'd0) begin n_fail++; $display("FAIL rst_sv_idx: got %h want 0", sv_idx); end
    n_cmp++; if (sv_data !== 32'h0) begin n_fail++; $display("FAIL rst_sv_data: got %h want 0", sv_data); end
    n_cmp++; if (rs_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rs_ready: got %b want 0", rs_ready); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL rst_conflict: got %b want 0", conflict); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata0: got %h want 0", rdata[0]); end
    n_cmp++; if (rdata[1] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata1: got %h want 0", rdata[1]); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_conflict();
    raddr[0] = 5'd5;
    we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
    wdata[0] = 32'hAAAA0000; wdata[1] = 32'h5555FFFF;
    @(negedge clk);
    n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL wc_nobypass_old: got %h want 0", rdata[0]); end
    n_cmp++; if (bp_rdata[0] !== 32'h5555FFFF) begin n_fail++; $display("FAIL wc_bypass_winner: got %h want 5555ffff", bp_rdata[0]); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL wc_flag_early: got %b want 0", conflict); end
    @(posedge clk); #1;
    we = 2'b00;
    @(negedge clk);
    n_cmp++; if (rdata[0] !== 32'h5555FFFF) begin n_fail++; $display("FAIL wc_winner: got %h want 5555ffff", rdata[0]); end
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL wc_flag: got %b want 1", conflict); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL wc_flag_pulse: got %b want 0", conflict); end
    @(posedge clk); #1;
    // Both ports write x0: dropped, not a conflict, never forwarded.
    we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0;
    wdata[0] = 32'h1234; wdata[1] = 32'h1234; raddr[0] = 5'd0;
    @(negedge clk);
    n_cmp++; if (bp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL x0_bypass: got %h want 0", bp_rdata[0]); end
    @(posedge clk); #1;
    we = 2'b00;
    @(negedge clk);
    n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL x0_read: got %h want 0", rdata[0]); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL x0_conflict: got %b want 0", conflict); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'hDEADBEEF;
    raddr[0] = 5'd7; raddr[1] = 5'd7;
    @(negedge clk);
    n_cmp++; if (bp_rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_rd0: got %h want deadbeef", bp_rdata[0]); end
    n_cmp++; if (bp_rdata[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_rd1: got %h want deadbeef", bp_rdata[1]); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL nobyp_old: got %h want 0", rdata[0]); end
    @(posedge clk); #1;
    we = 2'b00;
    @(negedge clk);
    n_cmp++; if (rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobyp_new0: got %h want deadbeef", rdata[0]); end
    n_cmp++; if (rdata[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobyp_new1: got %h want deadbeef", rdata[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    for (int i = 1; i < 32; i += 2) begin
      waddr[0] = 5'(i); wdata[0] = 32'(i * 17);
      waddr[1] = 5'(i + 1); wdata[1] = 32'((i + 1) * 17);
      we = (i + 1 < 32) ? 2'b11 : 2'b01;
      @(posedge clk); #1;
    end
    we = 2'b00; raddr[0] = 5'd1; raddr[1] = 5'd31;
    @(negedge clk);
    n_cmp++; if (rdata[0] !== 32'h11) begin n_fail++; $display("FAIL pre_x1: got %h want 11", rdata[0]); end
    n_cmp++; if (rdata[1] !== 32'h20F) begin n_fail++; $display("FAIL pre_x31: got %h want 20f", rdata[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_save_backpressure();
    int exp_i, stall, cycles, dones;
    bit fin;
    exp_i = 1; stall = 0; cycles = 0; dones = 0; fin = 1'b0;
    sv_ready = 1'b1; save_req = 1'b1;
    @(posedge clk); #1;
    save_req = 1'b0;
    while (!fin && cycles < 60) begin
      sv_ready = (exp_i == 4 && stall < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      cycles++;
      if (done) begin
        dones++; fin = 1'b1;
      end else begin
        n_cmp++; if (sv_valid !== 1'b1) begin n_fail++; $display("FAIL sv_valid@%0d: got %b want 1", exp_i, sv_valid); end
        n_cmp++; if (sv_idx !== 5'(exp_i)) begin n_fail++; $display("FAIL sv_idx: got %0d want %0d", sv_idx, exp_i); end
        n_cmp++; if (sv_data !== 32'(exp_i * 17)) begin n_fail++; $display("FAIL sv_data@%0d: got %h want %h", exp_i, sv_data, 32'(exp_i * 17)); end
        if (!sv_ready) stall++; else exp_i++;
      end
      @(posedge clk); #1;
    end
    sv_ready = 1'b1;
    n_cmp++; if (!fin) begin n_fail++; $display("FAIL save_timeout: got no done want done within 60 cycles"); end
    n_cmp++; if (exp_i !== 32) begin n_fail++; $display("FAIL save_count: got %0d want 32", exp_i); end
    n_cmp++; if (cycles !== 35) begin n_fail++; $display("FAIL save_cycles: got %0d want 35", cycles); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL save_busy_end: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL save_done_once: got %b want 0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_restore_lockout();
    int exp_i, cycles;
    bit fin;
    exp_i = 1; cycles = 0; fin = 1'b0;
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'hFFFF;
    restore_req = 1'b1;
    @(posedge clk); #1;
    restore_req = 1'b0;
    while (!fin && cycles < 100) begin
      rs_valid = (cycles % 2 == 0);
      rs_data  = 32'(32'h100 + exp_i);
      @(negedge clk);
      cycles++;
      if (done) begin
        fin = 1'b1; we = 2'b00; rs_valid = 1'b0;
      end else begin
        n_cmp++; if (rs_ready !== 1'b1) begin n_fail++; $display("FAIL rs_ready@%0d: got %b want 1", exp_i, rs_ready); end
        if (rs_valid) exp_i++;
      end
      @(posedge clk); #1;
    end
    we = 2'b00; rs_valid = 1'b0;
    n_cmp++; if (!fin) begin n_fail++; $display("FAIL restore_timeout: got no done want done within 100 cycles"); end
    n_cmp++; if (cycles !== 62) begin n_fail++; $display("FAIL restore_cycles: got %0d want 62", cycles); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      raddr[0] = 5'(i);
      #1;
      n_cmp++; if (rdata[0] !== ((i == 0) ? 32'h0 : 32'(32'h100 + i))) begin n_fail++; $display("FAIL restore_x%0d: got %h want %h", i, rdata[0], ((i == 0) ? 32'h0 : 32'(32'h100 + i))); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    int exp_i, cycles;
    bit fin;
    exp_i = 1; cycles = 0; fin = 1'b0;
    sv_ready = 1'b1; save_req = 1'b1; restore_req = 1'b1;
    @(posedge clk); #1;
    save_req = 1'b0;
    while (!fin && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        fin = 1'b1; restore_req = 1'b0;
      end else begin
        n_cmp++; if (sv_valid !== 1'b1) begin n_fail++; $display("FAIL sim_sv_valid: got %b want 1", sv_valid); end
        n_cmp++; if (rs_ready !== 1'b0) begin n_fail++; $display("FAIL sim_rs_ready: got %b want 0", rs_ready); end
        n_cmp++; if (sv_data !== 32'(32'h100 + exp_i)) begin n_fail++; $display("FAIL sim_sv_data@%0d: got %h want %h", exp_i, sv_data, 32'(32'h100 + exp_i)); end
        exp_i++;
      end
      @(posedge clk); #1;
    end
    restore_req = 1'b0;
    n_cmp++; if (!fin) begin n_fail++; $display("FAIL sim_timeout: got no done want done within 60 cycles"); end
    n_cmp++; if (cycles !== 32) begin n_fail++; $display("FAIL sim_cycles: got %0d want 32", cycles); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_no_late_restore: got busy %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_restore();
    int exp_i, cycles;
    exp_i = 1; cycles = 0;
    rs_valid = 1'b1; restore_req = 1'b1;
    @(posedge clk); #1;
    restore_req = 1'b0;
    while (exp_i < 10 && cycles < 40) begin
      rs_data = 32'(32'h200 + exp_i);
      @(negedge clk);
      cycles++;
      if (rs_ready) exp_i++;
      @(posedge clk); #1;
    end
    raddr[0] = 5'd5; raddr[1] = 5'd9;
    @(negedge clk);
    n_cmp++; if (rdata[0] !== 32'h205) begin n_fail++; $display("FAIL mid_x5: got %h want 205", rdata[0]); end
    n_cmp++; if (rdata[1] !== 32'h209) begin n_fail++; $display("FAIL mid_x9: got %h want 209", rdata[1]); end
    n_cmp++; if (rs_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rs_ready: got %b want 1", rs_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", done); end
    n_cmp++; if (rs_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rs_ready: got %b want 0", rs_ready); end
    n_cmp++; if (sv_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sv_valid: got %b want 0", sv_valid); end
    n_cmp++; if (sv_idx !== 5'd0) begin n_fail++; $display("FAIL mid_rst_sv_idx: got %h want 0", sv_idx); end
    n_cmp++; if (sv_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_sv_data: got %h want 0", sv_data); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL mid_rst_conflict: got %b want 0", conflict); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL mid_rst_x5: got %h want 0", rdata[0]); end
    rs_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      raddr[0] = 5'(i);
      #1;
      n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL mid_clear_x%0d: got %h want 0", i, rdata[0]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_write_conflict();
    test_bypass();
    test_preload();
    test_save_backpressure();
    test_restore_lockout();
    test_simultaneous();
    test_reset_mid_restore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want end before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_apmu_regfile_mp
`default_nettype wire

// File: doc/apmu_regfile_mp.md
# apmu_regfile_mp

Parametrised multi-port flip-flop register file for the APMU core, with a built-in context save/restore engine. It generalises the existing two-read/one-write FF register file: configurable read/write port counts, optional write-to-read bypass, and a sequential engine that streams the full register contents out, or back in, over valid/ready handshakes. It sits between the APMU decode/writeback stages and the context-switch controller.

## Interface
- DataWidth, 32: register width in bits.
- AddrWidth, 5: address bits; NumWords = 2**AddrWidth (5 gives 32 registers, 4 gives the RV32E set of 16).
- NumRead, 2: number of read ports, at least 1.
- NumWrite, 2: number of write ports, at least 1.
- WriteBypass, 0: 1 forwards same-cycle write data to matching reads.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- raddr_i  in  NumRead x AddrWidth  read addresses.
- rdata_o  out  NumRead x DataWidth  read data.
- waddr_i  in  NumWrite x AddrWidth  write addresses.
- wdata_i  in  NumWrite x DataWidth  write data.
- we_i  in  NumWrite  write enables.
- wr_conflict_o  out  1  registered pulse: two or more enabled ports targeted the same nonzero address last cycle.
- ctx_save_req_i  in  1  start save (level, sampled in IDLE).
- ctx_restore_req_i  in  1  start restore (level, sampled in IDLE).
- ctx_busy_o  out  1  engine active; architectural writes are ignored.
- ctx_done_o  out  1  one-cycle pulse when an operation completes.
- sv_valid_o  out  1  save stream valid.
- sv_ready_i  in  1  save stream ready.
- sv_idx_o  out  AddrWidth  register index of sv_data_o.
- sv_data_o  out  DataWidth  saved register value.
- rs_valid_i  in  1  restore stream valid.
- rs_ready_o  out  1  restore stream ready.
- rs_data_i  in  DataWidth  restore value.

## Operation
- R0 has no storage: it always reads 0, and writes to address 0 are dropped, including during restore.
- Writes: when several enabled ports hit the same address, the highest-index port wins. wr_conflict_o pulses the following cycle.
- Reads are combinational from storage. With WriteBypass=1, a read of address a (nonzero) returns the winning same-cycle wdata for a; with WriteBypass=0 it returns the old value.
- FSM states: IDLE, SAVE, RESTORE, DONE.
  - IDLE to SAVE on ctx_save_req_i. IDLE to RESTORE on ctx_restore_req_i. If both are asserted, save wins. Requests outside IDLE are ignored.
  - Entering SAVE or RESTORE loads the index counter with 1.
  - SAVE: sv_valid_o=1, sv_idx_o=idx, sv_data_o=reg[idx]. On sv_valid_o & sv_ready_i, idx increments. The transfer at idx=NumWords-1 moves the FSM to DONE.
  - RESTORE: rs_ready_o=1. On rs_valid_i & rs_ready_o, reg[idx] <= rs_data_i and idx increments. The transfer at idx=NumWords-1 moves the FSM to DONE.
  - DONE: ctx_done_o=1 for exactly one cycle, then IDLE.
- ctx_busy_o = (state != IDLE). While busy, we_i is ignored entirely (no write, no conflict flag). Read ports remain functional.
- idx is AddrWidth bits wide and never wraps; the FSM leaves SAVE or RESTORE before an overflow can occur.

## Timing
- Reset values: all registers 0, state IDLE, idx 0. Outputs: ctx_busy_o=0, ctx_done_o=0, sv_valid_o=0, sv_idx_o=0, sv_data_o=0, rs_ready_o=0, wr_conflict_o=0. rdata_o reflects the all-zero array.
- Writes are visible on rdata_o the cycle after the write edge, or the same cycle with WriteBypass=1.
- A request sampled at edge N gives busy=1 and the first sv_valid_o or rs_ready_o in cycle N+1.
- sv_idx_o and sv_data_o are held stable while sv_valid_o & !sv_ready_i. sv_valid_o never drops without a transfer.
- Minimum operation time with the stream always ready: NumWords-1 transfer cycles plus 1 DONE cycle.
- Reset asserted mid-operation aborts immediately to the reset state. Partially restored registers are cleared to 0.

## Structure
- Shared package apmu_regfile_pkg holds the ctx_state_e enum (IDLE, SAVE, RESTORE, DONE).
- Sub-module apmu_regfile_ctx_fsm holds the state, the index counter, the handshake outputs, and the restore write enable/address.
- The top level holds storage, the write-priority decoder, bypass muxing, and conflict detection.

## Test plan
- Write/read, NumWrite=2: port0 writes x5=0xAAAA0000 and port1 writes x5=0x5555FFFF in the same cycle → next cycle x5 reads 0x5555FFFF and wr_conflict_o=1 for one cycle. A write of 0x1234 to x0 → x0 still reads 0.
- Bypass, WriteBypass=1: a write of x7=0xDEADBEEF with raddr_i[0]=7 in the same cycle → rdata_o[0]=0xDEADBEEF that cycle. With WriteBypass=0 → old value that cycle, new value next cycle.
- Save with backpressure: preload xi=i*0x11 for i=1..31, pulse ctx_save_req_i, hold sv_ready_i low for 3 cycles at idx 4, otherwise high → 31 transfers with idx 1..31 and data i*0x11. Data is stable during the stall. ctx_done_o pulses once, then ctx_busy_o=0.
- Restore plus write lockout: restore stream of values 0x100+i, with rs_valid_i gapped every other cycle, while we_i writes x3=0xFFFF throughout → afterwards xi=0x100+i, x3=0x103, x0=0.
- Simultaneous save and restore requests → save runs. A restore request during busy is ignored.
- Reset mid-restore at idx 10 → all outputs return to reset values and every register reads 0.
